// File: rtl/uart_transmitter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_transmitter_if                                             |
// | Purpose  : Bundles the NIOS-side request/config signals and the TX-line    |
// |            outputs of the UART transmit path.                              |
// | Signals  : usr_options[7:0]   frame/baud configuration                     |
// |            data_out_nios[7:0] byte to transmit                             |
// |            send               transmit request                             |
// |            cts                clear-to-send from the far end               |
// |            serial_out         TX line (idles high)                         |
// |            busy               frame in progress                            |
// |            tx_done            one-cycle end-of-frame pulse                 |
// | Modports : master (requester side), slave (transmitter)                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface uart_transmitter_if;
  logic [7:0] usr_options;
  logic [7:0] data_out_nios;
  logic       send;
  logic       cts;
  logic       serial_out;
  logic       busy;
  logic       tx_done;

  modport master (
    output usr_options, data_out_nios, send, cts,
    input  serial_out, busy, tx_done
  );

  modport slave (
    input  usr_options, data_out_nios, send, cts,
    output serial_out, busy, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_transmitter                                                |
// | Purpose  : UART transmit path. Sends start bit, 5-8 data bits LSB first,   |
// |            optional parity and 1-2 stop bits at one of four baud rates     |
// |            derived from sys_clk. Optional CTS gating before the start bit. |
// | Ports    : sys_clk  system clock (rising edge)                             |
// |            reset    asynchronous active-low reset                          |
// |            bus      uart_transmitter_if.slave (options, data, send, cts,   |
// |                     serial_out, busy, tx_done)                             |
// | Params   : CLK_FREQ sys_clk frequency in Hz                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_transmitter #(
  parameter int CLK_FREQ = 50_000_000
) (
  input logic               sys_clk,
  input logic               reset,
  uart_transmitter_if.slave bus
);

  // Counter wide enough for the slowest (9600 baud) divisor.
  localparam int c_cnt_w = $clog2(CLK_FREQ / 9600 + 1);

  localparam logic [c_cnt_w-1:0] c_div_9600   = c_cnt_w'(CLK_FREQ / 9600);
  localparam logic [c_cnt_w-1:0] c_div_19200  = c_cnt_w'(CLK_FREQ / 19200);
  localparam logic [c_cnt_w-1:0] c_div_57600  = c_cnt_w'(CLK_FREQ / 57600);
  localparam logic [c_cnt_w-1:0] c_div_115200 = c_cnt_w'(CLK_FREQ / 115200);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CTS = 3'd1,
    S_START    = 3'd2,
    S_DATA     = 3'd3,
    S_PARITY   = 3'd4,
    S_STOP     = 3'd5
  } state_t;

  state_t             r_state,      w_state_next;
  logic [c_cnt_w-1:0] r_cnt,        w_cnt_next;
  logic [2:0]         r_bit_idx,    w_bit_idx_next;
  logic               r_stop_idx,   w_stop_idx_next;
  logic               r_serial_out, w_serial_next;

  // Frame settings captured at accept; only the fields that matter mid-frame.
  logic [7:0] r_data;
  logic       r_par_en;
  logic       r_par_odd;
  logic [1:0] r_len_code;
  logic       r_two_stop;
  logic [1:0] r_baud;

  logic               w_accept;
  logic               w_tx_done;
  logic [c_cnt_w-1:0] w_div_last;
  logic               w_bit_end;
  logic [2:0]         w_last_bit;
  logic               w_parity;

  always_comb begin
    w_div_last = c_div_115200 - c_cnt_w'(1);
    case (r_baud)
      2'd0:    w_div_last = c_div_9600   - c_cnt_w'(1);
      2'd1:    w_div_last = c_div_19200  - c_cnt_w'(1);
      2'd2:    w_div_last = c_div_57600  - c_cnt_w'(1);
      default: w_div_last = c_div_115200 - c_cnt_w'(1);
    endcase
  end

  assign w_bit_end  = (r_cnt == w_div_last);
  // Length code 00..11 maps to 8..5 data bits, so the last index is 7 - code.
  assign w_last_bit = 3'd7 - {1'b0, r_len_code};
  // Mask off the unsent high bits before reducing.
  assign w_parity   = (^(r_data & (8'hFF >> r_len_code))) ^ r_par_odd;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_accept        = 1'b0;
    w_tx_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.send) begin
          w_accept     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = bus.usr_options[5] ? S_WAIT_CTS : S_START;
        end
      end
      S_WAIT_CTS: begin
        if (bus.cts) begin
          w_cnt_next   = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
        end else begin
          w_cnt_next = r_cnt + c_cnt_w'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_bit_idx == w_last_bit) begin
            w_stop_idx_next = 1'b0;
            w_state_next    = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + c_cnt_w'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_next      = '0;
          w_stop_idx_next = 1'b0;
          w_state_next    = S_STOP;
        end else begin
          w_cnt_next = r_cnt + c_cnt_w'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_stop_idx == r_two_stop) begin
            w_tx_done    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_stop_idx_next = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + c_cnt_w'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // The line level is decoded from the state being entered so that the
    // registered output changes on the same edge as the state.
    case (w_state_next)
      S_START:  w_serial_next = 1'b0;
      S_DATA:   w_serial_next = r_data[w_bit_idx_next];
      S_PARITY: w_serial_next = w_parity;
      default:  w_serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= 1'b0;
      r_serial_out <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit_idx    <= w_bit_idx_next;
      r_stop_idx   <= w_stop_idx_next;
      r_serial_out <= w_serial_next;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_len_code <= '0;
      r_two_stop <= 1'b0;
      r_baud     <= '0;
    end else if (w_accept) begin
      r_data     <= bus.data_out_nios;
      r_par_en   <= bus.usr_options[0];
      r_par_odd  <= bus.usr_options[1];
      r_len_code <= bus.usr_options[3:2];
      r_two_stop <= bus.usr_options[4];
      r_baud     <= bus.usr_options[7:6];
    end
  end

  assign bus.serial_out = r_serial_out;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.tx_done    = w_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_transmitter                                             |
// | Purpose  : Self-checking bench for uart_transmitter. A reference model     |
// |            builds the expected bit list of each frame from the data byte   |
// |            and options; the TX line is compared slot by slot.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_transmitter;

  // Reduced clock so every baud rate keeps the run short:
  // divisors 120 / 60 / 20 / 10.
  localparam int CLK_FREQ = 1_152_000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   exp_bits[$];

  uart_transmitter_if bus ();

  uart_transmitter #(.CLK_FREQ(CLK_FREQ)) dut (
    .sys_clk (clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic int div_of(input logic [7:0] opts);
    int baud;
    case (opts[7:6])
      2'd0:    baud = 9600;
      2'd1:    baud = 19200;
      2'd2:    baud = 57600;
      default: baud = 115200;
    endcase
    return CLK_FREQ / baud;
  endfunction

  function automatic void build_frame(input logic [7:0] data, input logic [7:0] opts);
    int n;
    int ones;
    bit pb;
    n    = 8 - int'(opts[3:2]);
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (opts[0]) begin
      pb = ((ones % 2) == 1) ^ opts[1];
      exp_bits.push_back(pb);
    end
    exp_bits.push_back(1'b1);
    if (opts[4]) exp_bits.push_back(1'b1);
  endfunction

  // Called at the first start-bit sample; returns at the first post-frame sample.
  task automatic check_frame(input logic [7:0] data, input logic [7:0] opts,
                             input bit perturb, input string name);
    int div, len, bad, busy_bad, done_cnt, done_at, nb;
    div = div_of(opts);
    build_frame(data, opts);
    nb       = exp_bits.size();
    len      = nb * div;
    busy_bad = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < div; c++) begin
        if (bus.serial_out !== exp_bits[b]) bad++;
        if (bus.busy !== 1'b1) busy_bad++;
        if (bus.tx_done !== 1'b0) begin
          done_cnt++;
          done_at = b * div + c;
        end
        if (perturb) begin
          bus.usr_options   = 8'($urandom);
          bus.cts           = 1'($urandom);
          bus.send          = (b == 2 && c == 0);
          bus.data_out_nios = (b == 2 && c == 0) ? 8'hAA : 8'($urandom);
        end
        @(posedge clk); #1;
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s bit%0d: %0d of %0d cycles wrong, required level %0b",
                 name, b, bad, div, exp_bits[b]);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != len - 1) begin
      n_fail++;
      $display("FAIL %s tx_done: %0d pulses, last at cycle %0d, required 1 pulse at cycle %0d",
               name, done_cnt, done_at, len - 1);
    end
    n_cmp++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy: low in %0d frame cycles, required 0", name, busy_bad);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.serial_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s frame end: busy=%b serial_out=%b, required busy=0 serial_out=1",
               name, bus.busy, bus.serial_out);
    end
  endtask

  task automatic check_idle(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.busy !== 1'b0 || bus.serial_out !== 1'b1 || bus.tx_done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s idle: %0d of %0d cycles not idle, required 0", name, bad, n);
    end
  endtask

  task automatic start_frame(input logic [7:0] data, input logic [7:0] opts);
    bus.data_out_nios = data;
    bus.usr_options   = opts;
    bus.send          = 1'b1;
    @(posedge clk); #1;
    bus.send          = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.serial_out !== 1'b1) begin
      n_fail++; $display("FAIL reset serial_out: got %b, required 1", bus.serial_out);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset busy: got %b, required 0", bus.busy);
    end
    n_cmp++;
    if (bus.tx_done !== 1'b0) begin
      n_fail++; $display("FAIL reset tx_done: got %b, required 0", bus.tx_done);
    end
    rst_n = 1'b1;
    check_idle(4, "after_reset");
  endtask

  task automatic test_directed();
    start_frame(8'h55, 8'hC0);
    check_frame(8'h55, 8'hC0, 1'b1, "8N1_115200");
    bus.cts = 1'b0;
    check_idle(5, "8N1_115200");
    start_frame(8'hFF, 8'h15);
    check_frame(8'hFF, 8'h15, 1'b1, "7E2_9600");
    bus.cts = 1'b0;
    check_idle(5, "7E2_9600");
    start_frame(8'hE0, 8'hCF);
    check_frame(8'hE0, 8'hCF, 1'b0, "5O1_115200");
    check_idle(5, "5O1_115200");
  endtask

  task automatic test_random();
    logic [7:0] d, o;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      o = 8'($urandom) & 8'hDF;
      start_frame(d, o);
      check_frame(d, o, 1'(i % 2), "random");
      bus.cts = 1'b0;
      check_idle(3, "random");
    end
  endtask

  task automatic test_handshake();
    int bad;
    bus.cts = 1'b0;
    start_frame(8'h96, 8'hE3);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.busy !== 1'b1 || bus.serial_out !== 1'b1 || bus.tx_done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL handshake wait: %0d of 1000 cycles not busy/high, required 0", bad);
    end
    bus.cts = 1'b1;
    @(posedge clk); #1;
    check_frame(8'h96, 8'hE3, 1'b1, "handshake");
    bus.cts = 1'b0;
    check_idle(5, "handshake");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2, o1, o2;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    o1 = (8'($urandom) & 8'h1F) | 8'hC0;
    o2 = (8'($urandom) & 8'h1F) | 8'h80;
    bus.data_out_nios = d1;
    bus.usr_options   = o1;
    bus.send          = 1'b1;
    @(posedge clk); #1;
    bus.data_out_nios = d2;
    bus.usr_options   = o2;
    check_frame(d1, o1, 1'b0, "b2b_first");
    @(posedge clk); #1;
    bus.send = 1'b0;
    check_frame(d2, o2, 1'b0, "b2b_second");
    check_idle(5, "b2b");
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    logic [7:0] d;
    start_frame(8'h3C, 8'hC0);
    repeat (35) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.serial_out !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid immediate: serial_out=%b busy=%b tx_done=%b, required 1/0/0",
               bus.serial_out, bus.busy, bus.tx_done);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.serial_out !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid hold: %0d of 5 cycles not idle, required 0", bad);
    end
    check_idle(20, "reset_mid_release");
    d = 8'($urandom);
    start_frame(d, 8'h5B);
    check_frame(d, 8'h5B, 1'b0, "reset_mid_recover");
    check_idle(3, "reset_mid_recover");
  endtask

  initial begin
    bus.send          = 1'b0;
    bus.cts           = 1'b0;
    bus.data_out_nios = 8'h00;
    bus.usr_options   = 8'h00;
    rst_n             = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
